// File: rtl/pwm_duty_scheduler_if.sv
// Controller-side bundle of the PWM duty scheduler: enable level, config valid/ready
// channel and the observed PWM status; the scheduler takes the slave view.
interface pwm_duty_scheduler_if #(
    parameter int CNT_W = 8
);
    logic             enable;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CNT_W-1:0] cfg_period;
    logic [CNT_W-1:0] cfg_duty;
    logic             pwm_out;
    logic             period_start;
    logic [1:0]       state;
    logic [CNT_W-1:0] cur_duty;

    modport master (
        output enable, cfg_valid, cfg_period, cfg_duty,
        input  cfg_ready, pwm_out, period_start, state, cur_duty
    );

    modport slave (
        input  enable, cfg_valid, cfg_period, cfg_duty,
        output cfg_ready, pwm_out, period_start, state, cur_duty
    );
endinterface

// File: rtl/pwm_duty_scheduler.sv
// PWM period/duty scheduler: settings go via a one-deep shadow, applied only at period boundaries.
// Outputs registered, aligned to the counter; cfg_ready is low while the shadow holds an unapplied setting.
module pwm_duty_scheduler #(
    parameter int CNT_W          = 8,
    parameter int RAMP_STEP      = 1,
    parameter int DEFAULT_PERIOD = 20,
    parameter int DEFAULT_DUTY   = 2
) (
    input  logic                 clk1ms,
    input  logic                 reset,
    pwm_duty_scheduler_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RAMP  = 2'b01,
        RUN   = 2'b10,
        DRAIN = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cur_duty_q, cur_duty_d;
    logic [CNT_W-1:0] act_period_q, act_period_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic [CNT_W-1:0] pend_period_q, pend_period_d;
    logic [CNT_W-1:0] pend_duty_q, pend_duty_d;
    logic             pend_q, pend_d;
    logic             pwm_q, pwm_d;
    logic             ps_q, ps_d;

    logic             accept;
    logic             boundary;
    logic             consume;
    logic [CNT_W-1:0] cap_period;
    logic [CNT_W-1:0] cap_duty;
    logic [CNT_W-1:0] eff_period;
    logic [CNT_W-1:0] eff_target;
    logic [CNT_W:0]   ramp_sum;
    logic             ramp_sat;
    logic [CNT_W-1:0] ramp_duty;

    assign accept   = bus.cfg_valid && !pend_q;
    assign boundary = (state_q != IDLE) && (cnt_q == act_period_q - 1'b1);
    assign consume  = pend_q && ((state_q == IDLE) || boundary);

    // A zero period would never reach a boundary, so it is stored as one cycle.
    assign cap_period = (bus.cfg_period == '0) ? CNT_W'(1) : bus.cfg_period;
    assign cap_duty   = (bus.cfg_duty > cap_period) ? cap_period : bus.cfg_duty;

    // A setting released at this edge already governs the period that starts now.
    assign eff_period = consume ? pend_period_q : act_period_q;
    assign eff_target = consume ? pend_duty_q   : target_q;

    assign ramp_sum  = {1'b0, cur_duty_q} + (CNT_W+1)'(RAMP_STEP);
    assign ramp_sat  = (ramp_sum >= {1'b0, eff_target});
    assign ramp_duty = ramp_sat ? eff_target : ramp_sum[CNT_W-1:0];

    assign act_period_d  = eff_period;
    assign target_d      = eff_target;
    assign pend_d        = consume ? 1'b0 : (accept ? 1'b1 : pend_q);
    assign pend_period_d = accept ? cap_period : pend_period_q;
    assign pend_duty_d   = accept ? cap_duty   : pend_duty_q;

    always_ff @(posedge clk1ms or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            cur_duty_q    <= '0;
            act_period_q  <= CNT_W'(DEFAULT_PERIOD);
            target_q      <= CNT_W'(DEFAULT_DUTY);
            pend_period_q <= '0;
            pend_duty_q   <= '0;
            pend_q        <= 1'b0;
            pwm_q         <= 1'b0;
            ps_q          <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cur_duty_q    <= cur_duty_d;
            act_period_q  <= act_period_d;
            target_q      <= target_d;
            pend_period_q <= pend_period_d;
            pend_duty_q   <= pend_duty_d;
            pend_q        <= pend_d;
            pwm_q         <= pwm_d;
            ps_q          <= ps_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.enable) state_d = (eff_target == '0) ? RUN : RAMP;
            RAMP:    if (!bus.enable) state_d = DRAIN;
                     else if (boundary && ramp_sat) state_d = RUN;
            RUN:     if (!bus.enable) state_d = DRAIN;
            DRAIN:   if (bus.enable) state_d = RUN;
                     else if (boundary) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d      = cnt_q;
        cur_duty_d = cur_duty_q;
        case (state_q)
            IDLE: begin
                cnt_d      = '0;
                cur_duty_d = '0;
            end
            RAMP: begin
                cnt_d = boundary ? '0 : cnt_q + 1'b1;
                if (boundary) cur_duty_d = ramp_duty;
            end
            RUN: begin
                cnt_d = boundary ? '0 : cnt_q + 1'b1;
                if (boundary) cur_duty_d = eff_target;
            end
            default: begin
                cnt_d = boundary ? '0 : cnt_q + 1'b1;
                if (boundary) cur_duty_d = bus.enable ? eff_target : '0;
            end
        endcase
        // Registered from next-state values so pwm_out lines up with cnt without a lag cycle.
        pwm_d = (state_d != IDLE) && (cnt_d < cur_duty_d);
        ps_d  = (state_d != IDLE) && (cnt_d == '0);
    end

    assign bus.cfg_ready    = !pend_q;
    assign bus.pwm_out      = pwm_q;
    assign bus.period_start = ps_q;
    assign bus.state        = state_q;
    assign bus.cur_duty     = cur_duty_q;
endmodule

// File: tb/tb_pwm_duty_scheduler.sv
// Bench for pwm_duty_scheduler: directed scenarios plus random traffic against a period-level reference.
module tb_pwm_duty_scheduler;
    localparam int CNT_W     = 8;
    localparam int RAMP_STEP = 1;
    localparam int DEF_P     = 20;
    localparam int DEF_D     = 2;

    logic clk1ms = 1'b0;
    logic reset;
    always #5 clk1ms = ~clk1ms;

    pwm_duty_scheduler_if #(.CNT_W(CNT_W)) bus ();

    pwm_duty_scheduler #(
        .CNT_W(CNT_W), .RAMP_STEP(RAMP_STEP),
        .DEFAULT_PERIOD(DEF_P), .DEFAULT_DUTY(DEF_D)
    ) dut (
        .clk1ms(clk1ms),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference: mode 0 idle, 1 ramp, 2 run, 3 drain; position within period; queued settings.
    int m_state, m_cnt, m_cur, m_per, m_tgt;
    int q_per[$];
    int q_dut[$];

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_cur = 0; m_per = DEF_P; m_tgt = DEF_D;
        q_per.delete(); q_dut.delete();
    endtask

    task automatic model_step(input int en, input int v, input int p, input int d);
        bit bnd, acc;
        int cp, cd;
        acc = (v != 0) && (q_per.size() == 0);
        bnd = (m_state != 0) && (m_cnt == m_per - 1);
        if (q_per.size() != 0 && (m_state == 0 || bnd)) begin
            m_per = q_per.pop_front();
            m_tgt = q_dut.pop_front();
        end
        if (m_state == 0) begin
            if (en != 0) begin
                m_state = (m_tgt == 0) ? 2 : 1;
                m_cnt = 0;
                m_cur = 0;
            end
        end else begin
            m_cnt = bnd ? 0 : m_cnt + 1;
            case (m_state)
                1: begin
                    if (bnd) m_cur = (m_cur + RAMP_STEP < m_tgt) ? m_cur + RAMP_STEP : m_tgt;
                    if (en == 0) m_state = 3;
                    else if (bnd && m_cur == m_tgt) m_state = 2;
                end
                2: begin
                    if (bnd) m_cur = m_tgt;
                    if (en == 0) m_state = 3;
                end
                default: begin
                    if (en != 0) begin
                        m_state = 2;
                        if (bnd) m_cur = m_tgt;
                    end else if (bnd) begin
                        m_state = 0;
                        m_cur = 0;
                    end
                end
            endcase
        end
        if (acc) begin
            cp = (p == 0) ? 1 : p;
            cd = (d > cp) ? cp : d;
            q_per.push_back(cp);
            q_dut.push_back(cd);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("state",        bus.state,        m_state);
        chk("cur_duty",     bus.cur_duty,     m_cur);
        chk("pwm_out",      bus.pwm_out,      (m_state != 0) && (m_cnt < m_cur));
        chk("period_start", bus.period_start, (m_state != 0) && (m_cnt == 0));
        chk("cfg_ready",    bus.cfg_ready,    q_per.size() == 0);
    endtask

    task automatic cycle();
        model_step(bus.enable, bus.cfg_valid, bus.cfg_period, bus.cfg_duty);
        @(posedge clk1ms);
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_idle(input string tag);
        bus.enable = 1'b0;
        for (int k = 0; k < 300 && m_state != 0; k++) cycle();
        chk(tag, bus.state, 2'b00);
    endtask

    initial begin
        logic was_ready;
        reset = 1'b1;
        bus.enable = 1'b0; bus.cfg_valid = 1'b0; bus.cfg_period = '0; bus.cfg_duty = '0;
        model_reset();
        #23;
        check_all();
        reset = 1'b0;

        // Soft start from reset defaults: period 20, ramp 0 -> 1 -> 2.
        bus.enable = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            cycle();
            if (i == 1 || i == 21 || i == 41) chk("ramp_period_start", bus.period_start, 1);
            if (i == 21) chk("ramp_duty1", bus.cur_duty, 1);
            if (i == 41) chk("ramp_to_run", bus.state, 2'b10);
        end

        // New setting mid-period is held until the boundary.
        for (int k = 0; k < 40 && m_cnt != 7; k++) cycle();
        bus.cfg_valid = 1'b1; bus.cfg_period = 8'd10; bus.cfg_duty = 8'd5;
        cycle();
        chk("shadow_full", bus.cfg_ready, 0);
        bus.cfg_valid = 1'b0;
        run(45);
        chk("new_duty", bus.cur_duty, 5);

        // Drain from RUN, then restart and rescue a drain by re-enabling.
        for (int k = 0; k < 40 && !(m_state == 2 && m_cnt == 5); k++) cycle();
        bus.enable = 1'b0;
        for (int k = 0; k < 30 && m_state != 0; k++) cycle();
        chk("drain_done", bus.state, 2'b00);
        chk("drain_pwm", bus.pwm_out, 0);
        bus.enable = 1'b1;
        for (int k = 0; k < 100 && m_state != 2; k++) cycle();
        for (int k = 0; k < 40 && m_cnt != 5; k++) cycle();
        bus.enable = 1'b0;
        for (int k = 0; k < 20 && m_cnt != 8; k++) cycle();
        chk("in_drain", bus.state, 2'b11);
        bus.enable = 1'b1;
        cycle();
        chk("drain_rescued", bus.state, 2'b10);
        run(20);

        // Back-to-back offers with cfg_valid held.
        bus.cfg_valid = 1'b1; bus.cfg_period = 8'd30; bus.cfg_duty = 8'd6;
        cycle();
        chk("b2b_first_taken", bus.cfg_ready, 0);
        bus.cfg_period = 8'd12; bus.cfg_duty = 8'd3;
        for (int k = 0; k < 100; k++) begin
            was_ready = bus.cfg_ready;
            cycle();
            if (was_ready) break;
        end
        bus.cfg_valid = 1'b0;
        run(70);

        // Zero period and oversized duty in IDLE clamp to a 1-cycle, 100% waveform.
        wait_idle("idle_before_clamp");
        bus.cfg_valid = 1'b1; bus.cfg_period = 8'd0; bus.cfg_duty = 8'd7;
        cycle();
        bus.cfg_valid = 1'b0;
        cycle();
        bus.enable = 1'b1;
        run(6);
        chk("clamp_pwm_high", bus.pwm_out, 1);
        chk("clamp_duty", bus.cur_duty, 1);

        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 24) == 0) bus.enable = ~bus.enable;
            bus.cfg_valid  = ($urandom_range(0, 3) == 0);
            bus.cfg_period = 8'($urandom_range(0, 12));
            bus.cfg_duty   = 8'($urandom_range(0, 14));
            cycle();
        end
        bus.cfg_valid = 1'b0;

        // Asynchronous reset in the middle of a ramp.
        wait_idle("idle_before_reset");
        bus.cfg_valid = 1'b1; bus.cfg_period = 8'd20; bus.cfg_duty = 8'd2;
        cycle();
        bus.cfg_valid = 1'b0;
        bus.enable = 1'b1;
        for (int k = 0; k < 100 && !(m_state == 1 && m_cur == 1); k++) cycle();
        run(3);
        #3 reset = 1'b1;
        #1;
        chk("rst_state", bus.state, 2'b00);
        chk("rst_duty", bus.cur_duty, 0);
        chk("rst_pwm", bus.pwm_out, 0);
        chk("rst_ps", bus.period_start, 0);
        chk("rst_ready", bus.cfg_ready, 1);
        model_reset();
        #7 reset = 1'b0;
        for (int i = 1; i <= 45; i++) begin
            cycle();
            if (i == 21) chk("rst_default_period", bus.period_start, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
